// File: rtl/otter_cu_fsm_intr.sv
// Multicycle OTTER control unit with configurable memory latency and
// prioritised, edge-triggered interrupts with sticky pending bits.
module otter_cu_fsm_intr #(
    parameter int MEM_LATENCY = 1,
    parameter int NUM_INTR    = 4,
    localparam int IDW        = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [NUM_INTR-1:0] INTR,
    input  logic                MIE,
    input  logic [NUM_INTR-1:0] INTR_MASK,
    output logic                PCWRITE,
    output logic                REGWRITE,
    output logic                memWE2,
    output logic                memRDEN1,
    output logic                memRDEN2,
    output logic                PC_reset,
    output logic                csr_WE,
    output logic                mret_exec,
    output logic                int_taken,
    output logic [IDW-1:0]      INTR_ID
);

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_EXEC, S_WB, S_INTR
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [3:0] LAST_CNT  = 4'(MEM_LATENCY - 1);

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt, wait_cnt_nxt;
    logic [NUM_INTR-1:0]   sync1, sync2, sync3;
    logic [NUM_INTR-1:0]   pending, pending_nxt, rise, clr;
    logic [IDW-1:0]        id_nxt;
    logic                  last, is_load, retire, take;

    function automatic logic [IDW-1:0] first_set(input logic [NUM_INTR-1:0] v);
        first_set = '0;
        for (int i = NUM_INTR - 1; i >= 0; i--) begin
            if (v[i]) first_set = IDW'(i);
        end
    endfunction

    assign last    = (wait_cnt == LAST_CNT);
    assign is_load = (opcode == OP_LOAD);
    assign retire  = ((state == S_EXEC) && !is_load) || ((state == S_WB) && last);
    assign take    = MIE & (|(pending & INTR_MASK));
    assign rise    = sync2 & ~sync3;

    // Clearing the serviced bit must not swallow a new edge arriving the same cycle.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_INTR; i++) begin
            clr[i] = (state == S_INTR) && (INTR_ID == IDW'(i));
        end
        pending_nxt = (pending & ~clr) | rise;
        id_nxt      = (retire && take) ? first_set(pending & INTR_MASK) : INTR_ID;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_INIT;
            wait_cnt <= '0;
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            pending  <= '0;
            INTR_ID  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            sync1    <= INTR;
            sync2    <= sync1;
            sync3    <= sync2;
            pending  <= pending_nxt;
            INTR_ID  <= id_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        case (state)
            S_INIT:  state_nxt = S_FETCH;
            S_FETCH: begin
                if (last) state_nxt = S_EXEC;
                else      wait_cnt_nxt = wait_cnt + 4'd1;
            end
            S_EXEC: begin
                if (is_load)   state_nxt = S_WB;
                else if (take) state_nxt = S_INTR;
                else           state_nxt = S_FETCH;
            end
            S_WB: begin
                if (!last)     wait_cnt_nxt = wait_cnt + 4'd1;
                else if (take) state_nxt = S_INTR;
                else           state_nxt = S_FETCH;
            end
            S_INTR:  state_nxt = S_FETCH;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        PCWRITE   = 1'b0;
        REGWRITE  = 1'b0;
        memWE2    = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        PC_reset  = 1'b0;
        csr_WE    = 1'b0;
        mret_exec = 1'b0;
        int_taken = 1'b0;
        case (state)
            S_INIT:  PC_reset = 1'b1;
            S_FETCH: memRDEN1 = 1'b1;
            S_EXEC: begin
                case (opcode)
                    OP_LOAD:   memRDEN2 = 1'b1;
                    OP_STORE: begin
                        memWE2  = 1'b1;
                        PCWRITE = 1'b1;
                    end
                    OP_BRANCH: PCWRITE = 1'b1;
                    OP_SYS: begin
                        PCWRITE = 1'b1;
                        if (funct3 == 3'b000) begin
                            mret_exec = 1'b1;
                        end else begin
                            REGWRITE = 1'b1;
                            csr_WE   = 1'b1;
                        end
                    end
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_RTYPE, OP_ITYPE: begin
                        REGWRITE = 1'b1;
                        PCWRITE  = 1'b1;
                    end
                    default:   PCWRITE = 1'b1;
                endcase
            end
            S_WB: begin
                memRDEN2 = 1'b1;
                REGWRITE = last;
                PCWRITE  = last;
            end
            S_INTR: begin
                int_taken = 1'b1;
                PCWRITE   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm_intr.sv
// Bench for otter_cu_fsm_intr: a table-driven run at MEM_LATENCY=1 plus a
// hand-written load/reset sequence at MEM_LATENCY=3.
module tb_otter_cu_fsm_intr;

    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [6:0] BOGUS = 7'b0000000;

    // {PC_reset, memRDEN1, memRDEN2, memWE2, REGWRITE, PCWRITE, csr_WE, mret_exec, int_taken}
    localparam logic [8:0] O_INIT = 9'h100;
    localparam logic [8:0] O_FE   = 9'h080;
    localparam logic [8:0] O_ALU  = 9'h018;
    localparam logic [8:0] O_ST   = 9'h028;
    localparam logic [8:0] O_BR   = 9'h008;
    localparam logic [8:0] O_MRET = 9'h00A;
    localparam logic [8:0] O_CSR  = 9'h01C;
    localparam logic [8:0] O_LD   = 9'h040;
    localparam logic [8:0] O_WBL  = 9'h058;
    localparam logic [8:0] O_INT  = 9'h009;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       mie;
        logic [3:0] intr;
        logic [3:0] mask;
        logic [8:0] exp;
        logic [1:0] id;
    } vec_t;

    typedef struct {
        logic [10:0] exp;
        int          idx;
    } sb_t;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];
    sb_t  sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, mie_a = 1'b0;
    logic [6:0] op_a = ADDI;
    logic [2:0] f3_a = 3'b000;
    logic [3:0] intr_a = 4'h0, mask_a = 4'hF;
    logic       pcw_a, rw_a, we2_a, rd1_a, rd2_a, pcr_a, csr_a, mret_a, intk_a;
    logic [1:0] id_a;
    logic [10:0] outs_a;

    logic       rst_b = 1'b0, mie_b = 1'b0;
    logic [6:0] op_b = ADDI;
    logic [2:0] f3_b = 3'b000;
    logic [3:0] intr_b = 4'h0, mask_b = 4'hF;
    logic       pcw_b, rw_b, we2_b, rd1_b, rd2_b, pcr_b, csr_b, mret_b, intk_b;
    logic [1:0] id_b;
    logic [10:0] outs_b;

    assign outs_a = {pcr_a, rd1_a, rd2_a, we2_a, rw_a, pcw_a, csr_a, mret_a, intk_a, id_a};
    assign outs_b = {pcr_b, rd1_b, rd2_b, we2_b, rw_b, pcw_b, csr_b, mret_b, intk_b, id_b};

    otter_cu_fsm_intr #(.MEM_LATENCY(1), .NUM_INTR(4)) u_a (
        .CLK(clk), .RST(rst_a), .opcode(op_a), .funct3(f3_a), .INTR(intr_a),
        .MIE(mie_a), .INTR_MASK(mask_a), .PCWRITE(pcw_a), .REGWRITE(rw_a),
        .memWE2(we2_a), .memRDEN1(rd1_a), .memRDEN2(rd2_a), .PC_reset(pcr_a),
        .csr_WE(csr_a), .mret_exec(mret_a), .int_taken(intk_a), .INTR_ID(id_a)
    );

    otter_cu_fsm_intr #(.MEM_LATENCY(3), .NUM_INTR(4)) u_b (
        .CLK(clk), .RST(rst_b), .opcode(op_b), .funct3(f3_b), .INTR(intr_b),
        .MIE(mie_b), .INTR_MASK(mask_b), .PCWRITE(pcw_b), .REGWRITE(rw_b),
        .memWE2(we2_b), .memRDEN1(rd1_b), .memRDEN2(rd2_b), .PC_reset(pcr_b),
        .csr_WE(csr_b), .mret_exec(mret_b), .int_taken(intk_b), .INTR_ID(id_b)
    );

    task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic mie, input logic [3:0] intr, input logic [3:0] mask,
                       input logic [8:0] e, input logic [1:0] id);
        vec_t v;
        v.rst = r; v.op = op; v.f3 = f3; v.mie = mie;
        v.intr = intr; v.mask = mask; v.exp = e; v.id = id;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic cyc_b(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [8:0] e, input logic [1:0] id);
        @(negedge clk);
        op_b = op;
        f3_b = f3;
        #2;
        chk(nm, outs_b, {e, id});
    endtask

    // Scoreboard consumer: compares two time units after each falling edge.
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0) begin
            sb_t s;
            s = sb.pop_front();
            checks++;
            if (outs_a !== s.exp) begin
                failures++;
                $display("FAIL vec%0d got=%h want=%h", s.idx, outs_a, s.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, one INIT cycle, then each instruction class at latency 1
        add(0, ADDI, 3'b000, 0, 4'h0, 4'hF, O_INIT, 0);
        add(0, ADDI, 3'b000, 0, 4'h0, 4'hF, O_INIT, 0);
        add(1, ADDI, 3'b000, 0, 4'h0, 4'hF, O_INIT, 0);
        add(1, ADDI, 3'b000, 0, 4'h0, 4'hF, O_FE,   0);
        add(1, ADDI, 3'b000, 0, 4'h0, 4'hF, O_ALU,  0);
        add(1, SW,   3'b010, 0, 4'h0, 4'hF, O_FE,   0);
        add(1, SW,   3'b010, 0, 4'h0, 4'hF, O_ST,   0);
        add(1, BEQ,  3'b000, 0, 4'h0, 4'hF, O_FE,   0);
        add(1, BEQ,  3'b000, 0, 4'h0, 4'hF, O_BR,   0);
        add(1, SYS,  3'b001, 0, 4'h0, 4'hF, O_FE,   0);
        add(1, SYS,  3'b001, 0, 4'h0, 4'hF, O_CSR,  0);
        add(1, SYS,  3'b000, 0, 4'h0, 4'hF, O_FE,   0);
        add(1, SYS,  3'b000, 0, 4'h0, 4'hF, O_MRET, 0);
        add(1, LW,   3'b010, 0, 4'h0, 4'hF, O_FE,   0);
        add(1, LW,   3'b010, 0, 4'h0, 4'hF, O_LD,   0);
        add(1, LW,   3'b010, 0, 4'h0, 4'hF, O_WBL,  0);
        add(1, BOGUS,3'b000, 0, 4'h0, 4'hF, O_FE,   0);
        add(1, BOGUS,3'b000, 0, 4'h0, 4'hF, O_BR,   0);
        // Lines 1 and 3 rise during a FETCH; taken in priority order
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_FE,   0);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_ALU,  0);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_FE,   0);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_ALU,  0);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_INT,  1);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_FE,   1);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_ALU,  1);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_INT,  3);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_FE,   3);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_ALU,  3);
        add(1, ADDI, 3'b000, 1, 4'hA, 4'hF, O_FE,   3);
        // Line 0 pulses with MIE=0, then held off by the mask, then taken
        add(1, ADDI, 3'b000, 0, 4'h0, 4'hF, O_ALU,  3);
        add(1, ADDI, 3'b000, 0, 4'h1, 4'hF, O_FE,   3);
        add(1, ADDI, 3'b000, 0, 4'h0, 4'hF, O_ALU,  3);
        add(1, ADDI, 3'b000, 0, 4'h0, 4'hF, O_FE,   3);
        add(1, ADDI, 3'b000, 0, 4'h0, 4'hF, O_ALU,  3);
        add(1, ADDI, 3'b000, 1, 4'h0, 4'hE, O_FE,   3);
        add(1, ADDI, 3'b000, 1, 4'h0, 4'hE, O_ALU,  3);
        add(1, ADDI, 3'b000, 1, 4'h0, 4'hF, O_FE,   3);
        add(1, ADDI, 3'b000, 1, 4'h0, 4'hF, O_ALU,  3);
        add(1, ADDI, 3'b000, 1, 4'h0, 4'hF, O_INT,  0);
        add(1, ADDI, 3'b000, 1, 4'h0, 4'hF, O_FE,   0);

        for (int i = 0; i < tbl.size(); i++) begin
            sb_t s;
            @(negedge clk);
            rst_a  = tbl[i].rst;
            op_a   = tbl[i].op;
            f3_a   = tbl[i].f3;
            mie_a  = tbl[i].mie;
            intr_a = tbl[i].intr;
            mask_a = tbl[i].mask;
            s.exp  = {tbl[i].exp, tbl[i].id};
            s.idx  = i;
            sb.push_back(s);
        end
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain left=%0d want=0", sb.size());
        end

        // Latency-3 load, with a line-2 pulse while MIE=0, then reset mid-WB
        @(negedge clk);
        rst_b = 1'b1;
        #2;
        chk("b_init", outs_b, {O_INIT, 2'd0});
        intr_b = 4'h4;
        cyc_b("b_lw_f0", LW, 3'b010, O_FE,  0);
        cyc_b("b_lw_f1", LW, 3'b010, O_FE,  0);
        cyc_b("b_lw_f2", LW, 3'b010, O_FE,  0);
        cyc_b("b_lw_ex", LW, 3'b010, O_LD,  0);
        intr_b = 4'h0;
        cyc_b("b_lw_w0", LW, 3'b010, O_LD,  0);
        cyc_b("b_lw_w1", LW, 3'b010, O_LD,  0);
        cyc_b("b_lw_w2", LW, 3'b010, O_WBL, 0);
        cyc_b("b_lw2_f0", LW, 3'b010, O_FE, 0);
        cyc_b("b_lw2_f1", LW, 3'b010, O_FE, 0);
        cyc_b("b_lw2_f2", LW, 3'b010, O_FE, 0);
        cyc_b("b_lw2_ex", LW, 3'b010, O_LD, 0);
        cyc_b("b_lw2_w0", LW, 3'b010, O_LD, 0);
        chk("b_pend_set", {7'd0, u_b.pending}, 11'h004);
        #1;
        rst_b = 1'b0;
        #1;
        chk("b_rst_out", outs_b, {O_INIT, 2'd0});
        chk("b_rst_pend", {7'd0, u_b.pending}, 11'h000);
        @(negedge clk);
        rst_b = 1'b1;
        mie_b = 1'b1;
        #2;
        chk("b_re_init", outs_b, {O_INIT, 2'd0});
        cyc_b("b_re_f0", ADDI, 3'b000, O_FE,  0);
        cyc_b("b_re_f1", ADDI, 3'b000, O_FE,  0);
        cyc_b("b_re_f2", ADDI, 3'b000, O_FE,  0);
        cyc_b("b_re_ex", ADDI, 3'b000, O_ALU, 0);
        cyc_b("b_re_nf", ADDI, 3'b000, O_FE,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
